// File: rtl/ser_link_pkg.sv
// Shared types and constants for the ser_link serial transmit/receive link.
package ser_link_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_STOP = 2'd2
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pushes when full and pops when empty are ignored.
module sync_fifo
  import ser_link_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ser_link.sv
// Buffered framed serial link: TX FIFO -> serializer, deserializer -> RX FIFO.
module ser_link
  import ser_link_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] data_in,
  output logic             tx_full,
  output logic             tx_busy,
  output logic             ser_out,
  input  logic             ser_in,
  input  logic             rd,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_empty,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned BCW = clog2(WIDTH + 1);

  tx_state_t        tx_state, tx_state_n;
  logic [WIDTH-1:0] tx_shift, tx_shift_n, tx_head, tx_shifted;
  logic [BCW-1:0]   tx_cnt, tx_cnt_n;
  logic             ser_out_n, tx_pop, tx_empty, tx_bit;

  rx_state_t        rx_state, rx_state_n;
  logic [WIDTH-1:0] rx_shift, rx_shift_n, rx_head, rd_word;
  logic [BCW-1:0]   rx_cnt, rx_cnt_n;
  logic             rx_push, rx_full, rd_accept, rd_pend;
  logic             frame_err_n, overrun_n;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(wr), .push_data(data_in), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .push_data(rx_shift), .pop(rd_accept),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  assign tx_busy    = (tx_state != TX_IDLE);
  assign tx_bit     = (LSB_FIRST != 0) ? tx_shift[0] : tx_shift[WIDTH-1];
  assign tx_shifted = (LSB_FIRST != 0) ? (tx_shift >> 1) : (tx_shift << 1);

  always_comb begin
    tx_state_n = tx_state;
    tx_shift_n = tx_shift;
    tx_cnt_n   = tx_cnt;
    ser_out_n  = ser_out;
    tx_pop     = 1'b0;
    unique case (tx_state)
      TX_IDLE, TX_STOP: begin
        ser_out_n  = STOP_BIT;
        tx_state_n = TX_IDLE;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
          ser_out_n  = START_BIT;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        ser_out_n  = tx_bit;
        tx_shift_n = tx_shifted;
        tx_cnt_n   = BCW'(1);
        tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        if (tx_cnt == BCW'(WIDTH)) begin
          ser_out_n  = STOP_BIT;
          tx_state_n = TX_STOP;
        end else begin
          ser_out_n  = tx_bit;
          tx_shift_n = tx_shifted;
          tx_cnt_n   = tx_cnt + BCW'(1);
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_cnt   <= '0;
      ser_out  <= STOP_BIT;
    end else begin
      tx_state <= tx_state_n;
      tx_shift <= tx_shift_n;
      tx_cnt   <= tx_cnt_n;
      ser_out  <= ser_out_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_shift_n  = rx_shift;
    rx_cnt_n    = rx_cnt;
    rx_push     = 1'b0;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (ser_in == START_BIT) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_DATA;
        end
      end
      RX_DATA: begin
        rx_shift_n = (LSB_FIRST != 0) ? {ser_in, rx_shift[WIDTH-1:1]}
                                      : {rx_shift[WIDTH-2:0], ser_in};
        rx_cnt_n   = rx_cnt + BCW'(1);
        if (rx_cnt == BCW'(WIDTH - 1)) rx_state_n = RX_STOP;
      end
      RX_STOP: begin
        rx_state_n = RX_IDLE;
        if (ser_in == STOP_BIT) begin
          if (rx_full) overrun_n = 1'b1;
          else         rx_push   = 1'b1;
        end else begin
          frame_err_n = 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // The head word is captured when the pop is accepted, since the FIFO
  // advances on that same edge; it reaches rx_data one edge later.
  assign rd_accept = rd && !rx_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state  <= RX_IDLE;
      rx_shift  <= '0;
      rx_cnt    <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rd_pend   <= 1'b0;
      rd_word   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_state  <= rx_state_n;
      rx_shift  <= rx_shift_n;
      rx_cnt    <= rx_cnt_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
      rd_pend   <= rd_accept;
      if (rd_accept) rd_word <= rx_head;
      if (rd_pend)   rx_data <= rd_word;
      rx_valid  <= rd_pend;
    end
  end

endmodule

// File: tb/tb_ser_link.sv
// Loopback bench for ser_link: directed scenarios plus a randomized run
// against a frame-timing reference model built from queues.
module tb_ser_link;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int FL = W + 2;

  typedef struct packed {
    int           q;
    logic [W-1:0] w;
  } flight_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wr = 1'b0;
  logic         rd = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         loop_en = 1'b1;
  logic         line = 1'b1;
  logic         ser_in;
  logic         tx_full, tx_busy, ser_out, rx_valid, rx_empty, frame_err, overrun;
  logic [W-1:0] rx_data;
  int           n_checks = 0;
  int           n_pass = 0;

  assign ser_in = loop_en ? ser_out : line;

  always #5 clk = ~clk;

  ser_link #(.WIDTH(W), .DEPTH(D), .LSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .tx_full(tx_full),
    .tx_busy(tx_busy), .ser_out(ser_out), .ser_in(ser_in), .rd(rd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_empty(rx_empty),
    .frame_err(frame_err), .overrun(overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level for position i of a frame carrying w (LSB first).
  function automatic logic frame_bit(input logic [W-1:0] w, input int i);
    if (i == 0) return 1'b0;
    if (i <= W) return w[i-1];
    return 1'b1;
  endfunction

  task automatic test_reset();
    int bad;
    bad = 0;
    rst = 1'b0; wr = 1'b0; rd = 1'b0; loop_en = 1'b1;
    tick(); tick();
    n_checks++; if (ser_out !== 1'b1) $display("FAIL reset_ser_out: got %b want 1", ser_out); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0) $display("FAIL reset_tx_busy: got %b want 0", tx_busy); else n_pass++;
    n_checks++; if (tx_full !== 1'b0) $display("FAIL reset_tx_full: got %b want 0", tx_full); else n_pass++;
    n_checks++; if (rx_empty !== 1'b1) $display("FAIL reset_rx_empty: got %b want 1", rx_empty); else n_pass++;
    n_checks++; if (rx_data !== '0) $display("FAIL reset_rx_data: got %h want 00", rx_data); else n_pass++;
    n_checks++;
    if ({rx_valid, frame_err, overrun} !== 3'b000)
      $display("FAIL reset_pulses: got %b want 000", {rx_valid, frame_err, overrun});
    else n_pass++;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ser_out !== 1'b1 || rx_empty !== 1'b1 || frame_err !== 1'b0 ||
          overrun !== 1'b0 || tx_busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL idle_20: got %0d bad cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_single_frame();
    logic [W-1:0] w;
    w = 8'h12;
    data_in = w; wr = 1'b1;
    tick();
    wr = 1'b0;
    for (int i = 0; i < FL; i++) begin
      tick();
      n_checks++;
      if (ser_out !== frame_bit(w, i))
        $display("FAIL single_line_bit%0d: got %b want %b", i, ser_out, frame_bit(w, i));
      else n_pass++;
      if (i == 0) begin
        n_checks++; if (tx_busy !== 1'b1) $display("FAIL single_busy: got %b want 1", tx_busy); else n_pass++;
      end
    end
    n_checks++; if (rx_empty !== 1'b1) $display("FAIL single_empty_e10: got %b want 1", rx_empty); else n_pass++;
    tick();
    n_checks++; if (rx_empty !== 1'b0) $display("FAIL single_empty_e11: got %b want 0", rx_empty); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", tx_busy); else n_pass++;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL single_valid_early: got %b want 0", rx_valid); else n_pass++;
    tick();
    n_checks++; if (rx_data !== w) $display("FAIL single_rx_data: got %h want %h", rx_data, w); else n_pass++;
    n_checks++; if (rx_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", rx_valid); else n_pass++;
    tick();
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL single_valid_len: got %b want 0", rx_valid); else n_pass++;
    n_checks++; if (rx_empty !== 1'b1) $display("FAIL single_drained: got %b want 1", rx_empty); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [5];
    logic [W-1:0] got[$];
    logic         exp_bit;
    int           errs;
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h99};
    errs = 0;
    for (int j = 0; j < 70; j++) begin
      if (j < 5) begin
        wr = 1'b1; data_in = words[j];
      end else if (j == 5) begin
        n_checks++; if (tx_full !== 1'b1) $display("FAIL b2b_full: got %b want 1", tx_full); else n_pass++;
        wr = 1'b1; data_in = 8'h66;
      end else begin
        wr = 1'b0;
      end
      rd = !rx_empty;
      tick();
      if (j >= 1) begin
        exp_bit = ((j - 1) / FL < 5) ? frame_bit(words[(j - 1) / FL], (j - 1) % FL) : 1'b1;
        n_checks++;
        if (ser_out !== exp_bit) $display("FAIL b2b_line_e%0d: got %b want %b", j, ser_out, exp_bit);
        else n_pass++;
      end
      if (rx_valid === 1'b1) got.push_back(rx_data);
      if (frame_err !== 1'b0 || overrun !== 1'b0) errs++;
    end
    wr = 1'b0; rd = 1'b0;
    n_checks++; if (got.size() != 5) $display("FAIL b2b_count: got %0d words want 5", got.size()); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      if (k < got.size()) begin
        n_checks++;
        if (got[k] !== words[k]) $display("FAIL b2b_word%0d: got %h want %h", k, got[k], words[k]);
        else n_pass++;
      end
    end
    n_checks++; if (errs != 0) $display("FAIL b2b_err_pulses: got %0d want 0", errs); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0) $display("FAIL b2b_busy_end: got %b want 0", tx_busy); else n_pass++;
  endtask

  task automatic test_overrun();
    logic [W-1:0] words [5];
    logic [W-1:0] got[$];
    int           ov_cnt, ov_edge, fe_cnt;
    ov_cnt = 0; ov_edge = -1; fe_cnt = 0;
    for (int k = 0; k < 5; k++) words[k] = W'($urandom);
    rd = 1'b0;
    for (int j = 0; j < 60; j++) begin
      wr = (j < 5);
      if (j < 5) data_in = words[j];
      tick();
      if (overrun === 1'b1) begin ov_cnt++; ov_edge = j; end
      if (frame_err === 1'b1) fe_cnt++;
    end
    wr = 1'b0;
    n_checks++; if (ov_cnt != 1) $display("FAIL ovr_count: got %0d want 1", ov_cnt); else n_pass++;
    n_checks++; if (ov_edge != 5 * FL + 1) $display("FAIL ovr_edge: got %0d want %0d", ov_edge, 5 * FL + 1); else n_pass++;
    n_checks++; if (fe_cnt != 0) $display("FAIL ovr_frame_err: got %0d want 0", fe_cnt); else n_pass++;
    for (int j = 0; j < 10; j++) begin
      rd = (j < 6);
      tick();
      if (rx_valid === 1'b1) got.push_back(rx_data);
    end
    rd = 1'b0;
    n_checks++; if (got.size() != 4) $display("FAIL ovr_held: got %0d words want 4", got.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      if (k < got.size()) begin
        n_checks++;
        if (got[k] !== words[k]) $display("FAIL ovr_word%0d: got %h want %h", k, got[k], words[k]);
        else n_pass++;
      end
    end
    n_checks++; if (rx_empty !== 1'b1) $display("FAIL ovr_drained: got %b want 1", rx_empty); else n_pass++;
  endtask

  task automatic test_frame_err();
    logic [W-1:0] d;
    int           fe_cnt;
    fe_cnt = 0;
    loop_en = 1'b0; line = 1'b1;
    tick(); tick();
    d = W'($urandom);
    line = 1'b0; tick();
    for (int i = 0; i < W; i++) begin line = d[i]; tick(); end
    line = 1'b0; tick();
    n_checks++; if (frame_err !== 1'b1) $display("FAIL ferr_pulse: got %b want 1", frame_err); else n_pass++;
    line = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (frame_err === 1'b1) fe_cnt++;
    end
    n_checks++; if (fe_cnt != 0) $display("FAIL ferr_extra_pulses: got %0d want 0", fe_cnt); else n_pass++;
    n_checks++; if (rx_empty !== 1'b1) $display("FAIL ferr_empty: got %b want 1", rx_empty); else n_pass++;
    d = W'($urandom);
    line = 1'b0; tick();
    for (int i = 0; i < W; i++) begin line = d[i]; tick(); end
    line = 1'b1; tick();
    n_checks++; if (rx_empty !== 1'b0) $display("FAIL ferr_good_frame: got %b want 0", rx_empty); else n_pass++;
    rd = 1'b1; tick(); rd = 1'b0; tick();
    n_checks++; if (rx_data !== d) $display("FAIL ferr_good_data: got %h want %h", rx_data, d); else n_pass++;
    loop_en = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    int errs;
    errs = 0;
    wr = 1'b1; data_in = 8'h77; tick();
    data_in = 8'h88; tick();
    wr = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    rst = 1'b0; tick(); rst = 1'b1;
    n_checks++; if (ser_out !== 1'b1) $display("FAIL rmid_ser_out: got %b want 1", ser_out); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", tx_busy); else n_pass++;
    n_checks++; if (rx_empty !== 1'b1) $display("FAIL rmid_empty: got %b want 1", rx_empty); else n_pass++;
    tick(); tick();
    wr = 1'b1; data_in = 8'h5A; tick(); wr = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (frame_err !== 1'b0 || overrun !== 1'b0) errs++;
    end
    n_checks++; if (rx_empty !== 1'b0) $display("FAIL rmid_arrived: got %b want 0", rx_empty); else n_pass++;
    rd = 1'b1; tick(); rd = 1'b0; tick();
    n_checks++; if (rx_data !== 8'h5A) $display("FAIL rmid_data: got %h want 5a", rx_data); else n_pass++;
    for (int j = 0; j < 15; j++) begin
      tick();
      if (frame_err !== 1'b0 || overrun !== 1'b0) errs++;
    end
    n_checks++; if (rx_empty !== 1'b1) $display("FAIL rmid_no_spurious: got %b want 1", rx_empty); else n_pass++;
    n_checks++; if (errs != 0) $display("FAIL rmid_err_pulses: got %0d want 0", errs); else n_pass++;
  endtask

  // Model: a word accepted at edge p leaves the TX FIFO at edge
  // q = max(p+1, previous q + FL) and lands in RX at edge q + FL.
  task automatic test_random();
    flight_t      fl[$];
    logic [W-1:0] rxq[$];
    logic [W-1:0] exp_data, pend_w;
    logic         pend, exp_valid, exp_ov, full_b, empty_b;
    logic [12:0]  got_v, exp_v;
    int           last_q, q, occ;
    rst = 1'b0; wr = 1'b0; rd = 1'b0; loop_en = 1'b1;
    tick();
    rst = 1'b1;
    last_q = -100; pend = 1'b0; pend_w = '0; exp_data = '0;
    for (int t = 0; t < 1200; t++) begin
      occ = 0;
      foreach (fl[i]) if (fl[i].q >= t) occ++;
      wr = ($urandom_range(0, 3) == 0);
      data_in = W'($urandom);
      rd = (t < 600) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
      if (wr && occ < D) begin
        q = (t + 1 > last_q + FL) ? t + 1 : last_q + FL;
        last_q = q;
        fl.push_back('{q: q, w: data_in});
      end
      full_b  = (rxq.size() == D);
      empty_b = (rxq.size() == 0);
      exp_valid = pend;
      if (pend) exp_data = pend_w;
      pend = rd && !empty_b;
      if (pend) pend_w = rxq.pop_front();
      exp_ov = 1'b0;
      if (fl.size() > 0 && fl[0].q + FL == t) begin
        if (full_b) exp_ov = 1'b1;
        else rxq.push_back(fl[0].w);
        void'(fl.pop_front());
      end
      occ = 0;
      foreach (fl[i]) if (fl[i].q > t) occ++;
      tick();
      exp_v = {occ == D, rxq.size() == 0, exp_valid, exp_ov, 1'b0, exp_data};
      got_v = {tx_full, rx_empty, rx_valid, overrun, frame_err, rx_data};
      n_checks++;
      if (got_v !== exp_v)
        $display("FAIL rand_cycle%0d {full,empty,valid,ovr,ferr,data}: got %h want %h", t, got_v, exp_v);
      else n_pass++;
    end
    wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
